// File: rtl/riscv_control_pipe_pkg.sv
// Shared decode constants and pipeline control bundle for the RV32I control path.
// Latency: none (declarations only).
// Backpressure: none; the pipeline advances every cycle.
package riscv_ctrl_pkg;

    localparam int ALU_CTRL_W = 3;

    // Opcodes the main decoder accepts
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ALU operation codes; any other code makes the ALU output 0
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

    // Main-decoder to ALU-decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Control carried from ID into EX
    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  alu_src;
        logic                  illegal;
    } ctrl_e_t;

    // Control carried from EX into MEM
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_m_t;

    // Control carried from MEM into WB
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

endpackage

// File: rtl/riscv_control_pipe_if.sv
// Bundle of decode inputs and staged control outputs of the control pipe.
// Latency: none (wiring only).
// Backpressure: none; every signal is valid every cycle.
interface riscv_control_pipe_if #(
    parameter int ALUCTRL_W = 3
);
    logic [31:0]          InstrD;
    logic                 FlushE;
    logic                 ZeroE;
    logic [1:0]           ImmSrcD;
    logic                 RegWriteE;
    logic [1:0]           ResultSrcE;
    logic                 MemWriteE;
    logic                 AluSrcE;
    logic [ALUCTRL_W-1:0] AluControlE;
    logic                 PCSrcE;
    logic                 IllegalE;
    logic                 RegWriteM;
    logic                 MemWriteM;
    logic [1:0]           ResultSrcM;
    logic                 RegWriteW;
    logic [1:0]           ResultSrcW;

    // Datapath / hazard side: drives the instruction, flush and zero flag
    modport master (
        output InstrD, FlushE, ZeroE,
        input  ImmSrcD, RegWriteE, ResultSrcE, MemWriteE, AluSrcE, AluControlE,
               PCSrcE, IllegalE, RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW
    );

    // Control pipe side
    modport slave (
        input  InstrD, FlushE, ZeroE,
        output ImmSrcD, RegWriteE, ResultSrcE, MemWriteE, AluSrcE, AluControlE,
               PCSrcE, IllegalE, RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW
    );
endinterface

// File: rtl/riscv_control_pipe_alu_dec.sv
// ALU decoder: maps operation class and funct fields to an ALU control code.
// Latency: combinational.
// Backpressure: none.
module riscv_alu_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0]            i_alu_op,
    input  logic [2:0]            i_funct3,
    input  logic                  i_op5,
    input  logic                  i_funct7b5,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic                  o_illegal
);

    // Select the ALU operation; only register/immediate ALU ops look at funct3
    always_comb begin
        o_alu_control = ALU_ADD;
        o_illegal     = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // addi carries imm[10] in bit 30, so only R-type may subtract
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: begin
                        o_alu_control = ALU_ADD;
                        o_illegal     = 1'b1;
                    end
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_control_pipe.sv
// Control pipe: decodes InstrD and carries control through ID/EX, EX/MEM, MEM/WB.
// Latency: E outputs 1 cycle after InstrD, M 2 cycles, W 3 cycles; ImmSrcD/PCSrcE combinational.
// Backpressure: none; ID/EX loads every cycle, FlushE loads a zero bubble instead.
module riscv_control_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
)(
    input  logic                clk,
    input  logic                rst,
    riscv_control_pipe_if.slave ctrl
);

    logic [1:0]            w_imm_src;
    logic                  w_reg_write;
    logic                  w_alu_src;
    logic                  w_mem_write;
    logic [1:0]            w_result_src;
    logic                  w_branch;
    logic [1:0]            w_alu_op;
    logic                  w_jump;
    logic                  w_op_illegal;
    logic [ALU_CTRL_W-1:0] w_alu_control;
    logic                  w_alu_illegal;
    ctrl_e_t               w_ctrl_d;
    ctrl_e_t               r_ctrl_e;
    ctrl_m_t               r_ctrl_m;
    ctrl_w_t               r_ctrl_w;
    logic                  w_unused_instr;

    // Main decode on the opcode; unknown opcodes decode to a do-nothing bundle
    always_comb begin
        w_reg_write  = 1'b0;
        w_imm_src    = IMM_I;
        w_alu_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_result_src = RES_ALU;
        w_branch     = 1'b0;
        w_alu_op     = ALUOP_ADD;
        w_jump       = 1'b0;
        w_op_illegal = 1'b0;
        case (ctrl.InstrD[6:0])
            OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = RES_MEM;
            end
            OP_SW: begin
                w_imm_src    = IMM_S;
                w_alu_src    = 1'b1;
                w_mem_write  = 1'b1;
            end
            OP_R: begin
                w_reg_write  = 1'b1;
                w_alu_op     = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                w_imm_src    = IMM_B;
                w_branch     = 1'b1;
                w_alu_op     = ALUOP_SUB;
            end
            OP_IALU: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_alu_op     = ALUOP_FUNCT;
            end
            OP_JAL: begin
                w_reg_write  = 1'b1;
                w_imm_src    = IMM_J;
                w_result_src = RES_PC4;
                w_jump       = 1'b1;
            end
            default: w_op_illegal = 1'b1;
        endcase
    end

    riscv_alu_dec u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (ctrl.InstrD[14:12]),
        .i_op5         (ctrl.InstrD[5]),
        .i_funct7b5    (ctrl.InstrD[30]),
        .o_alu_control (w_alu_control),
        .o_illegal     (w_alu_illegal)
    );

    // Fields of the instruction the control path never looks at
    assign w_unused_instr = ^{ctrl.InstrD[31], ctrl.InstrD[29:15], ctrl.InstrD[11:7]};

    // An unsupported funct3 must not write the register file
    assign w_ctrl_d = '{
        reg_write:   w_reg_write & ~w_alu_illegal,
        result_src:  w_result_src,
        mem_write:   w_mem_write,
        jump:        w_jump,
        branch:      w_branch,
        alu_control: w_alu_control,
        alu_src:     w_alu_src,
        illegal:     w_op_illegal | w_alu_illegal
    };

    // ID/EX register: loads every cycle, a flush inserts an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_e <= '0;
        end else if (ctrl.FlushE) begin
            r_ctrl_e <= '0;
        end else begin
            r_ctrl_e <= w_ctrl_d;
        end
    end

    // EX/MEM register: always advances, so bubbles flow on as zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_m <= '0;
        end else begin
            r_ctrl_m <= '{reg_write:  r_ctrl_e.reg_write,
                          result_src: r_ctrl_e.result_src,
                          mem_write:  r_ctrl_e.mem_write};
        end
    end

    // MEM/WB register: always advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_w <= '0;
        end else begin
            r_ctrl_w <= '{reg_write:  r_ctrl_m.reg_write,
                          result_src: r_ctrl_m.result_src};
        end
    end

    assign ctrl.ImmSrcD     = w_imm_src;
    assign ctrl.RegWriteE   = r_ctrl_e.reg_write;
    assign ctrl.ResultSrcE  = r_ctrl_e.result_src;
    assign ctrl.MemWriteE   = r_ctrl_e.mem_write;
    assign ctrl.AluSrcE     = r_ctrl_e.alu_src;
    assign ctrl.AluControlE = r_ctrl_e.alu_control;
    assign ctrl.IllegalE    = r_ctrl_e.illegal;
    // Zero only matters for a branch; a jump always redirects
    assign ctrl.PCSrcE      = r_ctrl_e.jump | (r_ctrl_e.branch & ctrl.ZeroE);
    assign ctrl.RegWriteM   = r_ctrl_m.reg_write;
    assign ctrl.MemWriteM   = r_ctrl_m.mem_write;
    assign ctrl.ResultSrcM  = r_ctrl_m.result_src;
    assign ctrl.RegWriteW   = r_ctrl_w.reg_write;
    assign ctrl.ResultSrcW  = r_ctrl_w.result_src;

endmodule

// File: doc/riscv_control_pipe.md
Name: riscv_control_pipe

Overview:
- Control side of the pipelined RV32I core: decodes the instruction in ID and produces the ALU operation code and datapath control.
- Carries that control through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Consumes the ALU Zero flag in EX and drives the branch/jump redirect (PCSrcE).
- Supports the hazard unit's EX flush (bubble insertion).

Parameters:
- ALUCTRL_W, 3, width of ALU control code. Encodings: 000 add, 001 sub, 010 and, 011 or, 101 slt. All other codes make the ALU output 0.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- InstrD  in  32  instruction in decode stage
- FlushE  in  1  clear ID/EX control (bubble) at next edge
- ZeroE  in  1  ALU Zero flag (EX stage)
- ImmSrcD  out  2  immediate format, combinational from InstrD: 00 I, 01 S, 10 B, 11 J
- RegWriteE  out  1  registered ID/EX register-write enable
- ResultSrcE  out  2  registered ID/EX result-mux select: 00 ALU, 01 mem, 10 PC+4
- MemWriteE  out  1  registered ID/EX memory-write enable
- AluSrcE  out  1  registered ID/EX ALU B-operand select: 1 immediate
- AluControlE  out  ALUCTRL_W  registered ID/EX ALU operation
- PCSrcE  out  1  combinational redirect: JumpE OR (BranchE AND ZeroE)
- IllegalE  out  1  registered: unsupported opcode/funct in EX
- RegWriteM, MemWriteM  out  1 each  EX/MEM stage
- ResultSrcM  out  2  EX/MEM stage
- RegWriteW  out  1  MEM/WB stage
- ResultSrcW  out  2  MEM/WB stage

Behaviour:
- Main decode on InstrD[6:0]. Field order: RegWrite, ImmSrc, AluSrc, MemWrite, ResultSrc, Branch, AluOp, Jump.
  - lw 0000011: 1, 00, 1, 0, 01, 0, 00, 0
  - sw 0100011: 0, 01, 1, 1, 00, 0, 00, 0
  - R 0110011: 1, 00, 0, 0, 00, 0, 10, 0
  - beq 1100011: 0, 10, 0, 0, 00, 1, 01, 0
  - I-ALU 0010011: 1, 00, 1, 0, 00, 0, 10, 0
  - jal 1101111: 1, 11, 0, 0, 10, 0, 00, 1
  - Any other opcode: all zero, IllegalD=1.
- ALU decode:
  - AluOp 00 -> 000.
  - AluOp 01 -> 001.
  - AluOp 10, by funct3:
    - 000 -> 001 if (op[5] AND funct7[5]), else 000. I-type addi never subtracts.
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other -> 000 with IllegalD=1.
- Registered stages:
  - ID/EX holds RegWrite, ResultSrc, MemWrite, Jump, Branch, AluControl, AluSrc, Illegal.
  - EX/MEM holds RegWrite, ResultSrc, MemWrite.
  - MEM/WB holds RegWrite, ResultSrc.
  - Latency from InstrD to E outputs is 1 cycle; to M, 2 cycles; to W, 3 cycles.
- FlushE=1 at an edge loads ID/EX with all zeros (a NOP bubble). EX/MEM and MEM/WB still advance normally, so the bubble propagates as zeros.
- No stall input: ID hold is done by the IF/ID register outside this block. ID/EX loads every cycle.
- rst asserted: every registered output is 0 immediately, regardless of clock. PCSrcE=0 follows from this.
- Deassertion is synchronised upstream; the first edge after reset loads decoded InstrD.
- PCSrcE is combinational from E-stage registers and ZeroE; no registering.
- ZeroE is ignored unless BranchE=1.
- A flush and a taken redirect in the same cycle are legal. The next edge loads the bubble.
- IllegalE is informational only. Illegal ops write nothing (RegWrite=0, MemWrite=0).

Decomposition:
- Shared package riscv_ctrl_pkg:
  - opcode constants OP_LW, OP_SW, OP_R, OP_BEQ, OP_IALU, OP_JAL
  - ALU control constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - ImmSrc and ResultSrc encodings
- One sub-module, riscv_alu_dec: combinational (AluOp, funct3, op5, funct7b5) -> (AluControl, illegal).
- Main decoder and pipeline registers stay in the top.

Test Plan:
- Reset: assert rst mid-stream with 0x002081B3 in flight -> all E/M/W outputs 0 immediately and PCSrcE=0.
- R-type:
  - InstrD=0x002081B3 (add) -> next cycle AluControlE=000, RegWriteE=1, AluSrcE=0.
  - InstrD=0x402081B3 (sub) -> AluControlE=001.
  - InstrD=0x0020E1B3 (or) -> AluControlE=011.
- I-type: InstrD=0x40008193 (addi, imm bit30=1) -> AluControlE=000, AluSrcE=1, ImmSrcD=00.
- Load pipeline: InstrD=0x0040A283 (lw), then NOPs:
  - E: ResultSrcE=01.
  - M: ResultSrcM=01, RegWriteM=1.
  - W: ResultSrcW=01, RegWriteW=1.
- Branch: InstrD=0x00208463 (beq), ImmSrcD=10.
  - E with ZeroE=1 -> PCSrcE=1, AluControlE=001.
  - E with ZeroE=0 -> PCSrcE=0.
- Jump and flush:
  - InstrD=0x008000EF (jal) -> PCSrcE=1 regardless of ZeroE, ResultSrcE=10.
  - Same jal with FlushE=1 -> E stage all zero, PCSrcE=0, and zeros propagate to M and W.
- Illegal: InstrD=0x0000707F -> IllegalE=1, RegWriteE=0, MemWriteE=0.
